// File: rtl/idx_to_mask_acc_pkg.sv
// Shared definitions for the index-to-mask accumulator: FSM state codes and
// the index-to-one-hot helper used by the decoder.
package idx_to_mask_acc_pkg;

  // Widest mask the helper can decode; instances must keep W at or below this.
  localparam int MAX_W = 1024;

  // FSM state codes (plain constants so legacy code can compare against them).
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  // Returns a one-hot vector with bit idx set, or all zeros when idx >= w.
  // Callers truncate the result to their own mask width.
  function automatic logic [MAX_W-1:0] idx_to_onehot(input int unsigned idx,
                                                     input int unsigned w);
    logic [MAX_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (idx < w) begin
      idx_to_onehot = one << idx;
    end else begin
      idx_to_onehot = '0;
    end
  endfunction

endpackage

// File: rtl/idx_to_mask_acc_dec.sv
// D-to-W one-hot decoder with an in-range flag. Indices at or above W decode
// to an all-zero vector so they never touch the accumulator.
module idx_to_mask_acc_dec
  import idx_to_mask_acc_pkg::*;
#(
  parameter int W = 32,
  parameter int D = $clog2(W)
) (
  input  logic [D-1:0] idx,
  output logic [W-1:0] onehot,
  output logic         in_range
);

  // Decode the index; out-of-range values only raise the flag.
  always_comb begin
    onehot   = W'(idx_to_onehot(32'(idx), W));
    in_range = (32'(idx) < W);
  end

endmodule

// File: rtl/idx_to_mask_acc.sv
// Index-to-mask accumulator: ORs a stream of decoded bit indices into a W-bit
// mask and, once the beat flagged last is accepted, presents the finished mask
// with its population count plus duplicate and out-of-range flags.
module idx_to_mask_acc
  import idx_to_mask_acc_pkg::*;
#(
  parameter int W                = 32,
  parameter int OPT_OUTPUT_ZEROS = 0,
  parameter int D                = $clog2(W),
  parameter int C                = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [D-1:0] in_idx,
  input  logic         in_last,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_mask,
  output logic [C-1:0] out_cnt,
  output logic         out_dup,
  output logic         out_oor,
  input  logic         out_rdy
);

  logic [0:0]   state;
  logic [W-1:0] acc;
  logic [C-1:0] cnt;
  logic         dup;
  logic         oor;

  logic [W-1:0] onehot;
  logic         in_range;
  logic         accept;
  logic         already_set;
  logic         release_mask;

  idx_to_mask_acc_dec #(
    .W (W),
    .D (D)
  ) u_dec (
    .idx      (in_idx),
    .onehot   (onehot),
    .in_range (in_range)
  );

  // Handshake decodes; both ready/valid come straight from the registered state
  // so neither depends combinationally on the opposite side's valid/ready.
  always_comb begin
    in_rdy       = (state == ACCUM);
    out_vld      = (state == HOLD);
    accept       = in_vld && in_rdy;
    release_mask = out_vld && out_rdy;
    already_set  = ((acc & onehot) != '0);
  end

  // Accumulate accepted beats, park in HOLD after the last one, and clear
  // everything once the consumer takes the mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      dup   <= 1'b0;
      oor   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (in_range) begin
              if (already_set) begin
                dup <= 1'b1;
              end else begin
                acc <= acc | onehot;
                cnt <= cnt + C'(1);
              end
            end else begin
              oor <= 1'b1;
            end
            if (in_last) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (release_mask) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            dup   <= 1'b0;
            oor   <= 1'b0;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  // Present the live accumulator; in HOLD it is frozen until the handshake.
  always_comb begin
    out_mask = (OPT_OUTPUT_ZEROS != 0) ? ~acc : acc;
    out_cnt  = cnt;
    out_dup  = dup;
    out_oor  = oor;
  end

endmodule

// File: tb/tb_idx_to_mask_acc.sv
// Self-checking bench for idx_to_mask_acc: directed scenarios at W=8 and W=6
// (both output polarities) plus randomized index streams at W=32 checked
// against a set-based reference model.
module tb_idx_to_mask_acc;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  // W=8 instance
  logic       in8_vld, in8_last, in8_rdy, out8_vld, out8_dup, out8_oor, out8_rdy;
  logic [2:0] in8_idx;
  logic [7:0] out8_mask;
  logic [3:0] out8_cnt;

  // W=6 instances (normal and inverted output) sharing one input stream
  logic       in6_vld, in6_last, in6_rdy, out6_vld, out6_dup, out6_oor, out6_rdy;
  logic       in6z_rdy, out6z_vld, out6z_dup, out6z_oor;
  logic [2:0] in6_idx;
  logic [5:0] out6_mask, out6z_mask;
  logic [2:0] out6_cnt, out6z_cnt;

  // W=32 instance
  logic        in32_vld, in32_last, in32_rdy, out32_vld, out32_dup, out32_oor, out32_rdy;
  logic [4:0]  in32_idx;
  logic [31:0] out32_mask;
  logic [5:0]  out32_cnt;

  idx_to_mask_acc #(.W(8), .OPT_OUTPUT_ZEROS(0)) u8 (
    .clk(clk), .rst(rst), .in_vld(in8_vld), .in_idx(in8_idx), .in_last(in8_last),
    .in_rdy(in8_rdy), .out_vld(out8_vld), .out_mask(out8_mask), .out_cnt(out8_cnt),
    .out_dup(out8_dup), .out_oor(out8_oor), .out_rdy(out8_rdy));

  idx_to_mask_acc #(.W(6), .OPT_OUTPUT_ZEROS(0)) u6 (
    .clk(clk), .rst(rst), .in_vld(in6_vld), .in_idx(in6_idx), .in_last(in6_last),
    .in_rdy(in6_rdy), .out_vld(out6_vld), .out_mask(out6_mask), .out_cnt(out6_cnt),
    .out_dup(out6_dup), .out_oor(out6_oor), .out_rdy(out6_rdy));

  idx_to_mask_acc #(.W(6), .OPT_OUTPUT_ZEROS(1)) u6z (
    .clk(clk), .rst(rst), .in_vld(in6_vld), .in_idx(in6_idx), .in_last(in6_last),
    .in_rdy(in6z_rdy), .out_vld(out6z_vld), .out_mask(out6z_mask), .out_cnt(out6z_cnt),
    .out_dup(out6z_dup), .out_oor(out6z_oor), .out_rdy(out6_rdy));

  idx_to_mask_acc #(.W(32), .OPT_OUTPUT_ZEROS(0)) u32 (
    .clk(clk), .rst(rst), .in_vld(in32_vld), .in_idx(in32_idx), .in_last(in32_last),
    .in_rdy(in32_rdy), .out_vld(out32_vld), .out_mask(out32_mask), .out_cnt(out32_cnt),
    .out_dup(out32_dup), .out_oor(out32_oor), .out_rdy(out32_rdy));

  task automatic drive8(input logic [2:0] idx, input logic last);
    int guard = 0;
    in8_vld = 1'b1; in8_idx = idx; in8_last = last;
    while (in8_rdy !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (in8_rdy !== 1'b1) begin
      checks++;
      $display("[TB] FAIL drive8_timeout in_rdy got %b want 1", in8_rdy);
    end
    @(posedge clk); #1;
    in8_vld = 1'b0; in8_last = 1'b0;
  endtask

  task automatic drive6(input logic [2:0] idx, input logic last);
    int guard = 0;
    in6_vld = 1'b1; in6_idx = idx; in6_last = last;
    while (in6_rdy !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (in6_rdy !== 1'b1) begin
      checks++;
      $display("[TB] FAIL drive6_timeout in_rdy got %b want 1", in6_rdy);
    end
    @(posedge clk); #1;
    in6_vld = 1'b0; in6_last = 1'b0;
  endtask

  task automatic drive32(input logic [4:0] idx, input logic last);
    int guard = 0;
    in32_vld = 1'b1; in32_idx = idx; in32_last = last;
    while (in32_rdy !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (in32_rdy !== 1'b1) begin
      checks++;
      $display("[TB] FAIL drive32_timeout in_rdy got %b want 1", in32_rdy);
    end
    @(posedge clk); #1;
    in32_vld = 1'b0; in32_last = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic ack8();
    out8_rdy = 1'b1;
    @(posedge clk); #1;
    out8_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({out8_vld, in8_rdy, out8_mask, out8_cnt, out8_dup, out8_oor} !== {1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0}) begin
      $display("[TB] FAIL reset_w8 got vld=%b rdy=%b mask=%h cnt=%0d dup=%b oor=%b want 0 1 00 0 0 0",
               out8_vld, in8_rdy, out8_mask, out8_cnt, out8_dup, out8_oor);
    end else passes++;
    checks++;
    if ({out6z_vld, in6z_rdy, out6z_mask, out6z_cnt} !== {1'b0, 1'b1, 6'h3F, 3'd0}) begin
      $display("[TB] FAIL reset_w6z got vld=%b rdy=%b mask=%h cnt=%0d want 0 1 3f 0",
               out6z_vld, in6z_rdy, out6z_mask, out6z_cnt);
    end else passes++;
    checks++;
    if ({out32_vld, in32_rdy, out32_mask, out32_cnt} !== {1'b0, 1'b1, 32'h0, 6'd0}) begin
      $display("[TB] FAIL reset_w32 got vld=%b rdy=%b mask=%h cnt=%0d want 0 1 0 0",
               out32_vld, in32_rdy, out32_mask, out32_cnt);
    end else passes++;
  endtask

  task automatic test_basic();
    out8_rdy = 1'b1;
    drive8(3'd3, 1'b0);
    drive8(3'd0, 1'b0);
    drive8(3'd5, 1'b1);
    checks++;
    if (out8_vld !== 1'b1 || in8_rdy !== 1'b0) begin
      $display("[TB] FAIL basic_latency got vld=%b rdy=%b want 1 0", out8_vld, in8_rdy);
    end else passes++;
    checks++;
    if ({out8_mask, out8_cnt, out8_dup, out8_oor} !== {8'b0010_1001, 4'd3, 1'b0, 1'b0}) begin
      $display("[TB] FAIL basic_result got mask=%b cnt=%0d dup=%b oor=%b want 00101001 3 0 0",
               out8_mask, out8_cnt, out8_dup, out8_oor);
    end else passes++;
    @(posedge clk); #1;
    out8_rdy = 1'b0;
    checks++;
    if ({in8_rdy, out8_vld, out8_mask, out8_cnt} !== {1'b1, 1'b0, 8'h00, 4'd0}) begin
      $display("[TB] FAIL basic_release got rdy=%b vld=%b mask=%h cnt=%0d want 1 0 00 0",
               in8_rdy, out8_vld, out8_mask, out8_cnt);
    end else passes++;
  endtask

  task automatic test_dup();
    drive8(3'd2, 1'b0);
    drive8(3'd2, 1'b0);
    drive8(3'd7, 1'b1);
    checks++;
    if ({out8_vld, out8_mask, out8_cnt, out8_dup, out8_oor} !== {1'b1, 8'b1000_0100, 4'd2, 1'b1, 1'b0}) begin
      $display("[TB] FAIL dup_result got vld=%b mask=%b cnt=%0d dup=%b oor=%b want 1 10000100 2 1 0",
               out8_vld, out8_mask, out8_cnt, out8_dup, out8_oor);
    end else passes++;
    ack8();
  endtask

  task automatic test_oor();
    drive6(3'd6, 1'b0);
    drive6(3'd1, 1'b1);
    checks++;
    if ({out6_vld, out6_mask, out6_cnt, out6_dup, out6_oor} !== {1'b1, 6'b00_0010, 3'd1, 1'b0, 1'b1}) begin
      $display("[TB] FAIL oor_w6 got vld=%b mask=%b cnt=%0d dup=%b oor=%b want 1 000010 1 0 1",
               out6_vld, out6_mask, out6_cnt, out6_dup, out6_oor);
    end else passes++;
    checks++;
    if ({out6z_vld, out6z_mask, out6z_cnt, out6z_dup, out6z_oor} !== {1'b1, 6'b11_1101, 3'd1, 1'b0, 1'b1}) begin
      $display("[TB] FAIL oor_w6z got vld=%b mask=%b cnt=%0d dup=%b oor=%b want 1 111101 1 0 1",
               out6z_vld, out6z_mask, out6z_cnt, out6z_dup, out6z_oor);
    end else passes++;
    out6_rdy = 1'b1;
    @(posedge clk); #1;
    out6_rdy = 1'b0;
    checks++;
    if ({in6_rdy, out6_vld, out6_oor, out6z_vld} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("[TB] FAIL oor_release got rdy=%b vld=%b oor=%b zvld=%b want 1 0 0 0",
               in6_rdy, out6_vld, out6_oor, out6z_vld);
    end else passes++;
  endtask

  task automatic test_backpressure();
    out8_rdy = 1'b0;
    drive8(3'd1, 1'b0);
    drive8(3'd4, 1'b1);
    in8_vld = 1'b1; in8_idx = 3'd6; in8_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out8_vld, in8_rdy, out8_mask, out8_cnt, out8_dup} !== {1'b1, 1'b0, 8'h12, 4'd2, 1'b0}) begin
        $display("[TB] FAIL backpressure_hold cycle %0d got vld=%b rdy=%b mask=%h cnt=%0d dup=%b want 1 0 12 2 0",
                 c, out8_vld, in8_rdy, out8_mask, out8_cnt, out8_dup);
      end else passes++;
      @(posedge clk); #1;
    end
    out8_rdy = 1'b1;
    @(posedge clk); #1;
    out8_rdy = 1'b0;
    checks++;
    if ({out8_vld, in8_rdy, out8_mask, out8_cnt} !== {1'b0, 1'b1, 8'h00, 4'd0}) begin
      $display("[TB] FAIL backpressure_cleared got vld=%b rdy=%b mask=%h cnt=%0d want 0 1 00 0",
               out8_vld, in8_rdy, out8_mask, out8_cnt);
    end else passes++;
    @(posedge clk); #1;
    in8_vld = 1'b0; in8_last = 1'b0;
    checks++;
    if ({out8_vld, out8_mask, out8_cnt} !== {1'b1, 8'h40, 4'd1}) begin
      $display("[TB] FAIL backpressure_heldbeat got vld=%b mask=%h cnt=%0d want 1 40 1",
               out8_vld, out8_mask, out8_cnt);
    end else passes++;
    ack8();
  endtask

  task automatic test_full_and_reset();
    for (int i = 0; i < 8; i++) begin
      drive8(3'(i), (i == 7));
    end
    checks++;
    if ({out8_vld, out8_mask, out8_cnt, out8_dup} !== {1'b1, 8'hFF, 4'd8, 1'b0}) begin
      $display("[TB] FAIL full_mask got vld=%b mask=%h cnt=%0d dup=%b want 1 ff 8 0",
               out8_vld, out8_mask, out8_cnt, out8_dup);
    end else passes++;
    pulse_reset();
    checks++;
    if ({out8_vld, in8_rdy, out8_mask, out8_cnt} !== {1'b0, 1'b1, 8'h00, 4'd0}) begin
      $display("[TB] FAIL reset_drops_pending got vld=%b rdy=%b mask=%h cnt=%0d want 0 1 00 0",
               out8_vld, in8_rdy, out8_mask, out8_cnt);
    end else passes++;
    drive8(3'd1, 1'b0);
    drive8(3'd4, 1'b0);
    pulse_reset();
    checks++;
    if ({out8_vld, in8_rdy, out8_mask, out8_cnt} !== {1'b0, 1'b1, 8'h00, 4'd0}) begin
      $display("[TB] FAIL reset_midstream got vld=%b rdy=%b mask=%h cnt=%0d want 0 1 00 0",
               out8_vld, in8_rdy, out8_mask, out8_cnt);
    end else passes++;
    drive8(3'd6, 1'b1);
    checks++;
    if ({out8_vld, out8_mask, out8_cnt, out8_dup, out8_oor} !== {1'b1, 8'h40, 4'd1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL after_reset_mask got vld=%b mask=%h cnt=%0d dup=%b oor=%b want 1 40 1 0 0",
               out8_vld, out8_mask, out8_cnt, out8_dup, out8_oor);
    end else passes++;
    ack8();
  endtask

  task automatic test_random32();
    bit          seen [32];
    logic [31:0] exp_mask;
    logic [4:0]  idx;
    logic        exp_dup;
    int          len, distinct, repeats, guard;
    bit          hs;
    for (int m = 0; m < 30; m++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < 32; i++) seen[i] = 1'b0;
      distinct = 0; repeats = 0; exp_mask = '0;
      for (int b = 0; b < len; b++) begin
        idx = 5'($urandom_range(0, 31));
        if (seen[idx]) repeats++;
        else begin
          seen[idx] = 1'b1;
          distinct++;
        end
        exp_mask[idx] = 1'b1;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        out32_rdy = 1'($urandom_range(0, 1));
        drive32(idx, (b == len - 1));
      end
      exp_dup = (repeats > 0);
      hs = 1'b0; guard = 0;
      while (!hs && guard < 100) begin
        checks++;
        if ({out32_vld, in32_rdy, out32_mask, out32_cnt, out32_dup, out32_oor} !==
            {1'b1, 1'b0, exp_mask, 6'(distinct), exp_dup, 1'b0}) begin
          $display("[TB] FAIL rand_mask %0d got vld=%b rdy=%b mask=%h cnt=%0d dup=%b oor=%b want 1 0 %h %0d %b 0",
                   m, out32_vld, in32_rdy, out32_mask, out32_cnt, out32_dup, out32_oor,
                   exp_mask, distinct, exp_dup);
        end else passes++;
        out32_rdy = 1'($urandom_range(0, 1));
        hs = out32_rdy;
        @(posedge clk); #1;
        guard++;
      end
      if (!hs) begin
        checks++;
        $display("[TB] FAIL rand_handshake_timeout mask %0d got no handshake want one", m);
      end
      out32_rdy = 1'b0;
      checks++;
      if ({out32_vld, in32_rdy, out32_mask, out32_cnt} !== {1'b0, 1'b1, 32'h0, 6'd0}) begin
        $display("[TB] FAIL rand_release %0d got vld=%b rdy=%b mask=%h cnt=%0d want 0 1 0 0",
                 m, out32_vld, in32_rdy, out32_mask, out32_cnt);
      end else passes++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in8_vld = 1'b0;  in8_idx = '0;  in8_last = 1'b0;  out8_rdy = 1'b0;
    in6_vld = 1'b0;  in6_idx = '0;  in6_last = 1'b0;  out6_rdy = 1'b0;
    in32_vld = 1'b0; in32_idx = '0; in32_last = 1'b0; out32_rdy = 1'b0;
    test_reset();
    test_basic();
    test_dup();
    test_oor();
    test_backpressure();
    test_full_and_reset();
    test_random32();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
